// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the MNIST inference sequencer and its argmax unit.
package nn_seq_pkg;
    localparam int NN_N_OUT    = 10;
    localparam int NN_OUT_W    = 16;
    localparam int NN_IDX_W    = $clog2(NN_N_OUT);
    localparam int NN_L_HIDDEN = 0;
    localparam int NN_L_OUTPUT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_L0,
        S_RUN_L1,
        S_ARGMAX,
        S_COMMIT
    } nn_seq_state_t;
endpackage

// File: rtl/nn_inference_sequencer_if.sv
// Frame / layer-engine / score-file handshake bundle; master is the sequencer side.
interface nn_inference_sequencer_if #(
    parameter int N_OUT = 10,
    parameter int OUT_W = 16
);
    localparam int IDX_W = $clog2(N_OUT);

    logic                    frame_valid;
    logic                    frame_ack;
    logic [1:0]              layer_start;
    logic [1:0]              layer_done;
    logic [IDX_W-1:0]        score_idx;
    logic signed [OUT_W-1:0] score;

    modport master (
        input  frame_valid, layer_done, score,
        output frame_ack, layer_start, score_idx
    );

    modport slave (
        output frame_valid, layer_done, score,
        input  frame_ack, layer_start, score_idx
    );
endinterface

// File: rtl/nn_argmax_unit.sv
// Running signed maximum over a streamed score vector; ties keep the earliest index.
module nn_argmax_unit #(
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic                step,
    input  logic signed [W-1:0] score,
    input  logic [IW-1:0]       idx,
    output logic [IW-1:0]       best_idx
);
    logic signed [W-1:0] best_q, best_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;

    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (clear) begin
            best_d     = '0;
            best_idx_d = '0;
        end else if (load || (step && (score > best_q))) begin
            best_d     = score;
            best_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_idx = best_idx_q;
endmodule

// File: rtl/nn_inference_sequencer.sv
// Sequences frame capture, hidden/output layer runs and the argmax commit to the display.
// Optional layer watchdog: define NN_SEQ_TIMEOUT_EN.
module nn_inference_sequencer
    import nn_seq_pkg::*;
#(
    parameter int N_OUT       = NN_N_OUT,
    parameter int OUT_W       = NN_OUT_W,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    nn_inference_sequencer_if.master bus,
    output logic [3:0]               digit,
    output logic                     digit_valid,
    output logic                     busy,
    output logic                     error
);
    localparam int IDX_W = $clog2(N_OUT);
    localparam int CNT_W = $clog2(N_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OUT);

    nn_seq_state_t    state_q, state_d;
    logic             frame_ack_q, frame_ack_d;
    logic [1:0]       layer_start_q, layer_start_d;
    logic [IDX_W-1:0] score_idx_q, score_idx_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_valid_q, digit_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_nxt;

    logic             am_clear, am_load, am_step;
    logic [IDX_W-1:0] am_idx, best_idx;

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    assign cnt_nxt = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        frame_ack_d   = 1'b0;
        layer_start_d = 2'b00;
        score_idx_d   = score_idx_q;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        cnt_d         = cnt_q;
        am_clear      = 1'b0;
        am_load       = 1'b0;
        am_step       = 1'b0;
        am_idx        = IDX_W'(cnt_q - CNT_W'(1));
`ifdef NN_SEQ_TIMEOUT_EN
        wd_d          = wd_q;
        error_d       = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.frame_valid) begin
                    state_d                    = S_RUN_L0;
                    frame_ack_d                = 1'b1;
                    layer_start_d[NN_L_HIDDEN] = 1'b1;
`ifdef NN_SEQ_TIMEOUT_EN
                    wd_d                       = '0;
                    error_d                    = 1'b0;
`endif
                end
            end
            // The start-pulse cycle itself never counts as a done.
            S_RUN_L0: begin
                if (!layer_start_q[NN_L_HIDDEN] && bus.layer_done[NN_L_HIDDEN]) begin
                    state_d                    = S_RUN_L1;
                    layer_start_d[NN_L_OUTPUT] = 1'b1;
`ifdef NN_SEQ_TIMEOUT_EN
                    wd_d                       = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            S_RUN_L1: begin
                if (!layer_start_q[NN_L_OUTPUT] && bus.layer_done[NN_L_OUTPUT]) begin
                    state_d     = S_ARGMAX;
                    cnt_d       = '0;
                    score_idx_d = '0;
                    am_clear    = 1'b1;
`ifdef NN_SEQ_TIMEOUT_EN
                end else if (wd_q == WD_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            // score arrives one cycle behind score_idx, so cycle c judges index c-1.
            S_ARGMAX: begin
                am_load     = (cnt_q == CNT_W'(1));
                am_step     = (cnt_q > CNT_W'(1));
                cnt_d       = cnt_nxt;
                score_idx_d = (cnt_nxt < CNT_LAST) ? IDX_W'(cnt_nxt) : '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                end
            end
            S_COMMIT: begin
                digit_d       = 4'(best_idx);
                digit_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            frame_ack_q   <= 1'b0;
            layer_start_q <= 2'b00;
            score_idx_q   <= '0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            frame_ack_q   <= frame_ack_d;
            layer_start_q <= layer_start_d;
            score_idx_q   <= score_idx_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef NN_SEQ_TIMEOUT_EN
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    nn_argmax_unit #(.N(N_OUT), .W(OUT_W), .IW(IDX_W)) u_argmax (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .clear    (am_clear),
        .load     (am_load),
        .step     (am_step),
        .score    (bus.score),
        .idx      (am_idx),
        .best_idx (best_idx)
    );

    assign bus.frame_ack   = frame_ack_q;
    assign bus.layer_start = layer_start_q;
    assign bus.score_idx   = score_idx_q;
    assign digit           = digit_q;
    assign digit_valid     = digit_valid_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench for nn_inference_sequencer with a score-file model and a digit scoreboard.
module tb_nn_inference_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nn_inference_sequencer_if #(.N_OUT(10), .OUT_W(16)) sif ();

    logic [3:0] digit;
    logic       digit_valid, busy, error;

    nn_inference_sequencer #(.N_OUT(10), .OUT_W(16), .TIMEOUT_CYC(64)) dut (
        .CLOCK_50    (clk),
        .resetn      (rstn),
        .bus         (sif.master),
        .digit       (digit),
        .digit_valid (digit_valid),
        .busy        (busy),
        .error       (error)
    );

    logic signed [15:0] mem [10];
    always @(posedge clk) sif.score <= mem[sif.score_idx];

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int exp_q[$];

    always @(negedge clk) if (sif.frame_ack === 1'b1) ack_cnt <= ack_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input int d0, input int d1, input int expd, input bit hold, input bit stray);
        exp_q.push_back(expd);
        sif.frame_valid = 1'b1;
        tick();
        chk("ack", 32'(sif.frame_ack), 1);
        chk("start_l0", 32'(sif.layer_start), 1);
        chk("busy_run", 32'(busy), 1);
        chk("err_clr", 32'(error), 0);
        if (!hold) sif.frame_valid = 1'b0;
        tick();
        chk("ack_once", 32'(sif.frame_ack), 0);
        chk("start_pulse", 32'(sif.layer_start), 0);
        if (stray) begin
            sif.layer_done = 2'b10;
            tick();
            sif.layer_done = 2'b00;
            chk("stray_no_l1", 32'(sif.layer_start), 0);
            chk("stray_busy", 32'(busy), 1);
        end
        repeat (d0) tick();
        sif.layer_done = 2'b01;
        tick();
        sif.layer_done = 2'b00;
        chk("start_l1", 32'(sif.layer_start), 2);
        repeat (d1) tick();
        sif.layer_done = 2'b10;
        tick();
        sif.layer_done = 2'b00;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("idx%0d", c), 32'(sif.score_idx), 32'(c));
            tick();
        end
        chk("busy_argmax_end", 32'(busy), 1);
        tick();
        chk("busy_commit", 32'(busy), 1);
        tick();
        chk("busy_drop", 32'(busy), 0);
        chk("dvalid", 32'(digit_valid), 1);
        chk("digit", 32'(digit), 32'(exp_q.pop_front()));
    endtask

    initial begin
        int a0;
        sif.frame_valid = 1'b0;
        sif.layer_done  = 2'b00;
        for (int i = 0; i < 10; i++) mem[i] = '0;

        repeat (2) tick();
        chk("rst_ack", 32'(sif.frame_ack), 0);
        chk("rst_start", 32'(sif.layer_start), 0);
        chk("rst_idx", 32'(sif.score_idx), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_dvalid", 32'(digit_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(error), 0);
        rstn = 1'b1;
        tick();

        // nominal, tie between index 2 and 3, stray output-layer done during L0
        mem = '{16'sd5, -16'sd3, 16'sd7, 16'sd7, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1};
        a0 = ack_cnt;
        run_pass(20, 15, 2, 1'b0, 1'b1);
        chk("ack_count1", 32'(ack_cnt - a0), 1);

        // all negative, frame_valid held across two back-to-back passes
        mem = '{-16'sd9, -16'sd4, -16'sd4, -16'sd8, -16'sd50, -16'sd60, -16'sd70, -16'sd80, -16'sd90, -16'sd100};
        a0 = ack_cnt;
        run_pass(5, 7, 1, 1'b1, 1'b0);
        mem = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100};
        run_pass(3, 4, 9, 1'b0, 1'b0);
        chk("ack_count2", 32'(ack_cnt - a0), 2);

`ifdef NN_SEQ_TIMEOUT_EN
        sif.frame_valid = 1'b1;
        tick();
        sif.frame_valid = 1'b0;
        chk("to_start", 32'(sif.layer_start), 1);
        repeat (63) tick();
        chk("to_err_pre", 32'(error), 0);
        chk("to_busy_pre", 32'(busy), 1);
        tick();
        chk("to_err", 32'(error), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_digit_kept", 32'(digit), 9);
        chk("to_dvalid_kept", 32'(digit_valid), 1);
`endif

        // all equal: lowest index wins
        mem = '{-16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7, -16'sd7};
        run_pass(2, 2, 0, 1'b0, 1'b0);

        // abort in ARGMAX with reset, then a clean pass
        mem = '{16'sd5, -16'sd3, 16'sd7, 16'sd7, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1};
        run_pass(4, 4, 2, 1'b0, 1'b0);
        sif.frame_valid = 1'b1;
        tick();
        sif.frame_valid = 1'b0;
        repeat (3) tick();
        sif.layer_done = 2'b01;
        tick();
        sif.layer_done = 2'b00;
        repeat (3) tick();
        sif.layer_done = 2'b10;
        tick();
        sif.layer_done = 2'b00;
        repeat (4) tick();
        chk("pre_rst_idx", 32'(sif.score_idx), 4);
        #2 rstn = 1'b0;
        #1;
        chk("arst_idx", 32'(sif.score_idx), 0);
        chk("arst_digit", 32'(digit), 0);
        chk("arst_dvalid", 32'(digit_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_start", 32'(sif.layer_start), 0);
        chk("arst_ack", 32'(sif.frame_ack), 0);
        chk("arst_err", 32'(error), 0);
        tick();
        rstn = 1'b1;
        tick();
        mem = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd40, 16'sd8, 16'sd9, 16'sd10};
        run_pass(6, 6, 6, 1'b0, 1'b0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
